// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : pong_pkg
//  Brief     : Shared constants and types for the pong level/score logic.
//  Revision  : 1.0  initial release
// ============================================================================
package pong_pkg;

  localparam int MAX_LVL    = 7;
  localparam int LVL_W      = 3;
  localparam int STEP_CNT_W = 26;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_ZERO = 4'd0;
  localparam bcd_digit_t BCD_NINE = 4'd9;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/bcd_counter2.sv
`default_nettype none
// ============================================================================
//  Module    : bcd_counter2
//  Brief     : Two-digit BCD up-counter, saturating at 99, with sync clear.
//  Revision  : 1.0  initial release
// ============================================================================
module bcd_counter2
  import pong_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] count
);

  bcd_digit_t tens;
  bcd_digit_t ones;
  logic       at_max;

  assign at_max = (tens == BCD_NINE) && (ones == BCD_NINE);
  assign count  = {tens, ones};

  // Clear wins over increment; increment carries ones into tens and stops at 99.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= BCD_ZERO;
      ones <= BCD_ZERO;
    end else if (clr) begin
      tens <= BCD_ZERO;
      ones <= BCD_ZERO;
    end else if (inc && !at_max) begin
      if (ones == BCD_NINE) begin
        ones <= BCD_ZERO;
        tens <= tens + 4'd1;
      end else begin
        ones <= ones + 4'd1;
      end
    end
  end

endmodule : bcd_counter2
`default_nettype wire

// File: rtl/hit_level_tracker.sv
`default_nettype none
// ============================================================================
//  Module    : hit_level_tracker
//  Brief     : Counts paddle hits (BCD score), advances a 0..7 level every
//              HITS_PER_LVL hits and generates the ball step tick whose period
//              shrinks as the level rises.
//  Revision  : 1.0  initial release
// ============================================================================
module hit_level_tracker
  import pong_pkg::*;
#(
  parameter int BASE_PERIOD  = 50_000_000,
  parameter int PERIOD_DEC   = 5_000_000,
  parameter int HITS_PER_LVL = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Hit_ld,
  input  logic             Hit_clr,
  input  logic             Lvl_clr,
  input  logic             T20_en,
  input  logic             T20_rst,
  output logic             step_tick,
  output logic [7:0]       hits_bcd,
  output logic [LVL_W-1:0] level,
  output logic             lvl_up,
  output logic             max_lvl
);

  localparam int SUB_W = (HITS_PER_LVL > 1) ? $clog2(HITS_PER_LVL) : 1;

  localparam logic [SUB_W-1:0]      SUB_LAST = SUB_W'(HITS_PER_LVL - 1);
  localparam logic [LVL_W-1:0]      LVL_TOP  = LVL_W'(MAX_LVL);
  localparam logic [STEP_CNT_W-1:0] BASE_C   = STEP_CNT_W'(BASE_PERIOD);
  localparam logic [STEP_CNT_W-1:0] DEC_C    = STEP_CNT_W'(PERIOD_DEC);

  // The shortest period (level 7) must leave at least two counts, and the
  // longest must fit the step counter.
  generate
    if ((BASE_PERIOD - MAX_LVL * PERIOD_DEC < 2) ||
        (BASE_PERIOD > (1 << STEP_CNT_W)) || (HITS_PER_LVL < 1)) begin : g_bad_params
      $error("hit_level_tracker: illegal BASE_PERIOD/PERIOD_DEC/HITS_PER_LVL");
    end
  endgenerate

  logic                  hit_low;   // last sample of Hit_ld was low (0 after reset)
  logic                  hit_evt;
  logic [SUB_W-1:0]      sub_cnt;
  logic                  sub_last;
  logic                  lvl_wrap;
  logic [STEP_CNT_W-1:0] step_cnt;
  logic [STEP_CNT_W-1:0] period_m1;
  logic                  step_hit;

  // A hit needs a low sample first, so Hit_ld held high across reset release
  // is ignored until it has been seen low.
  assign hit_evt  = Hit_ld & hit_low;
  assign sub_last = (sub_cnt == SUB_LAST);
  assign lvl_wrap = hit_evt & ~Hit_clr & sub_last;
  assign max_lvl  = (level == LVL_TOP);

  // Register Hit_ld (inverted) for rising-edge detection.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) hit_low <= 1'b0;
    else      hit_low <= ~Hit_ld;
  end

  bcd_counter2 u_score (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (Hit_clr),
    .inc   (hit_evt),
    .count (hits_bcd)
  );

  // Sub-counter and level: Hit_clr cancels the hit, Lvl_clr cancels the level-up.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sub_cnt <= '0;
      level   <= '0;
      lvl_up  <= 1'b0;
    end else begin
      lvl_up <= 1'b0;
      if (Hit_clr) begin
        sub_cnt <= '0;
      end else if (hit_evt) begin
        sub_cnt <= sub_last ? '0 : sub_cnt + SUB_W'(1);
      end
      if (Lvl_clr) begin
        level   <= '0;
        sub_cnt <= '0;
      end else if (lvl_wrap && (level != LVL_TOP)) begin
        level  <= level + LVL_W'(1);
        lvl_up <= 1'b1;
      end
    end
  end

  // Terminal count follows the level immediately; >= lets a count left
  // beyond a freshly shortened period terminate on the next enabled cycle.
  assign period_m1 = BASE_C - (STEP_CNT_W'(level) * DEC_C) - STEP_CNT_W'(1);
  assign step_hit  = (step_cnt >= period_m1);
  assign step_tick = T20_en & ~T20_rst & step_hit;

  // Step counter: clear, else count with wrap at terminal, else hold.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      step_cnt <= '0;
    end else if (T20_rst) begin
      step_cnt <= '0;
    end else if (T20_en) begin
      step_cnt <= step_hit ? '0 : step_cnt + STEP_CNT_W'(1);
    end
  end

endmodule : hit_level_tracker
`default_nettype wire
